alu_arbiter: RTL

Shares the single 32-bit ALU between two requesters, requester 0 and requester 1, such as the main execute path and an address/branch helper. It grants one request per cycle with round-robin priority and drives the winner's operands and ALU_Ctrl into an internal `alu` instance. The result, zero flag and requester ID go into a one-entry output register with valid/ready backpressure, so consumers never see combinational ALU paths.

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU.
// The winner's operation is computed combinationally by the alu instance
// and captured in a one-entry output register with valid/ready handshake,
// so no operand or ctrl input reaches an output combinationally.

// Shared ALU: add/sub/and/or/unsigned slt; unknown codes fall back to add.
module alu #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [3:0]    ctrl_i,
  output logic [DW-1:0] result_o,
  output logic          zero_o,
  output logic          illegal_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  // Operation decode; every path wraps modulo 2^DW, no overflow flag.
  always_comb begin
    result_o  = a_i + b_i;
    illegal_o = 1'b0;
    case (ctrl_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_SLT: result_o = {{(DW-1){1'b0}}, (a_i < b_i)};
      default: begin
        result_o  = a_i + b_i;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// Arbiter plus registered result stage. Only DW=32 is meaningful.
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [3:0]    req0_ctrl,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req1_ctrl,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          res_id,
  output logic          res_illegal
);

  logic          last_grant_q, last_grant_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_zero_q, res_zero_d;
  logic          res_id_q, res_id_d;
  logic          res_illegal_q, res_illegal_d;

  logic          grant_vld;
  logic          grant_id;
  logic          can_accept;
  logic          xfer;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_illegal;

  // Round-robin pick: a lone valid wins, a tie goes to the one not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  // Output slot is free or being drained this cycle; rst_n keeps readys low in reset.
  assign can_accept = ~res_valid_q | res_ready;
  assign xfer       = rst_n & grant_vld & can_accept;
  assign req0_ready = xfer & ~grant_id;
  assign req1_ready = xfer & grant_id;

  // Steer the granted requester's operation into the shared ALU.
  always_comb begin
    alu_a    = req0_a;
    alu_b    = req0_b;
    alu_ctrl = req0_ctrl;
    if (grant_id) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  alu #(.DW(DW)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .illegal_o(alu_illegal)
  );

  // Next state: load on transfer, clear valid on a pure drain, otherwise hold.
  always_comb begin
    last_grant_d  = last_grant_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_id_d      = res_id_q;
    res_illegal_d = res_illegal_q;
    if (xfer) begin
      last_grant_d  = grant_id;
      res_valid_d   = 1'b1;
      res_data_d    = alu_result;
      res_zero_d    = alu_zero;
      res_id_d      = grant_id;
      res_illegal_d = alu_illegal;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers; reset gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_id_q      <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_id_q      <= res_id_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_id      = res_id_q;
  assign res_illegal = res_illegal_q;

endmodule
